// File: rtl/agc_creg_pkg.sv
// Shared constants and ones'-complement arithmetic for the AGC central registers.
package agc_creg_pkg;

    localparam int CREG_WBITS = 16;
    localparam int CREG_SBITS = 12;

    localparam logic [CREG_WBITS-1:0] MINUS_ZERO = 16'hFFFF;

    // 16-bit ones'-complement sum with a single end-around carry fold.
    function automatic logic [CREG_WBITS-1:0] oc_add(
        input logic [CREG_WBITS-1:0] x,
        input logic [CREG_WBITS-1:0] y,
        input logic                  ci
    );
        logic [CREG_WBITS:0]   raw_s;
        logic [CREG_WBITS-1:0] sum_s;
        raw_s = {1'b0, x} + {1'b0, y} + {{CREG_WBITS{1'b0}}, ci};
        sum_s = raw_s[CREG_WBITS-1:0] + {{(CREG_WBITS-1){1'b0}}, raw_s[CREG_WBITS]};
        return sum_s;
    endfunction

endpackage

// File: rtl/agc_oc_adder.sv
// End-around-carry adder producing U = X + Y + CI in ones' complement.
module agc_oc_adder
    import agc_creg_pkg::*;
(
    input  logic [CREG_WBITS:1] x,
    input  logic [CREG_WBITS:1] y,
    input  logic                ci,
    output logic [CREG_WBITS:1] u
);

    assign u = oc_add(x, y, ci);

endmodule

// File: rtl/agc_central_regs.sv
// Central registers A/B/G/L/Z/S, adder inputs X/Y/CI, write-bus mux and branch bits,
// driven by the active-low control pulses of each timing cycle.
module agc_central_regs
    import agc_creg_pkg::*;
#(
    parameter int WBITS = CREG_WBITS,
    parameter int SBITS = CREG_SBITS
) (
    input  logic             CLOCK,
    input  logic             rst,
    input  logic             RA_,
    input  logic             RB_,
    input  logic             RC_,
    input  logic             RG_,
    input  logic             RL_,
    input  logic             RZ_,
    input  logic             RU_,
    input  logic             WA_,
    input  logic             WB_,
    input  logic             WG_,
    input  logic             WL_,
    input  logic             WZ_,
    input  logic             WS_,
    input  logic             WY_,
    input  logic             WYD_,
    input  logic             WY12_,
    input  logic             A2X_,
    input  logic             CI_,
    input  logic             TSGN_,
    input  logic             TOV_,
    input  logic             TMZ_,
    output logic [WBITS:1]   WL,
    output logic [SBITS:1]   S,
    output logic             Z15_,
    output logic             Z16_,
    output logic             BR1,
    output logic             BR2,
    output logic             BR1_,
    output logic             BR2_
);

    logic [WBITS:1] a_r;
    logic [WBITS:1] b_r;
    logic [WBITS:1] g_r;
    logic [WBITS:1] l_r;
    logic [WBITS:1] z_r;
    logic [WBITS:1] x_r;
    logic [WBITS:1] y_r;
    logic           ci_r;
    logic [SBITS:1] s_r;
    logic           br1_r;
    logic           br2_r;

    logic [WBITS:1] u_s;
    logic [WBITS:1] wl_s;
    logic [WBITS:1] y_next_s;
    logic           any_wy_s;
    logic           minus_zero_s;

    // Gate a register onto the bus only while its active-low read pulse is asserted.
    function automatic logic [WBITS:1] rd(input logic [WBITS:1] v, input logic pulse_n);
        return v & {WBITS{~pulse_n}};
    endfunction

    agc_oc_adder u_adder (
        .x  (x_r),
        .y  (y_r),
        .ci (ci_r),
        .u  (u_s)
    );

    assign wl_s = rd(a_r, RA_) | rd(b_r, RB_) | rd(~b_r, RC_) | rd(g_r, RG_)
                | rd(l_r, RL_) | rd(z_r, RZ_) | rd(u_s, RU_);

    assign any_wy_s     = ~(WY_ & WYD_ & WY12_);
    assign minus_zero_s = (wl_s == MINUS_ZERO);

    // Y source selection; WY_ outranks WYD_, which outranks WY12_.
    always_comb begin
        y_next_s = y_r;
        if (!WY_) begin
            y_next_s = wl_s;
        end else if (!WYD_) begin
            y_next_s = {wl_s[WBITS-1:1], wl_s[WBITS]};
        end else if (!WY12_) begin
            y_next_s = {{(WBITS-SBITS){1'b0}}, wl_s[SBITS:1]};
        end else begin
            y_next_s = y_r;
        end
    end

    // Central registers load the current bus at the end of the cycle.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            a_r <= {WBITS{1'b0}};
            b_r <= {WBITS{1'b0}};
            g_r <= {WBITS{1'b0}};
            l_r <= {WBITS{1'b0}};
            z_r <= {WBITS{1'b0}};
            s_r <= {SBITS{1'b0}};
        end else begin
            if (!WA_) a_r <= wl_s;
            if (!WB_) b_r <= wl_s;
            if (!WG_) g_r <= wl_s;
            if (!WL_) l_r <= wl_s;
            if (!WZ_) z_r <= wl_s;
            if (!WS_) s_r <= wl_s[SBITS:1];
        end
    end

    // Adder operands; A2X_ overrides the X clear that accompanies any WY pulse.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            x_r  <= {WBITS{1'b0}};
            y_r  <= {WBITS{1'b0}};
            ci_r <= 1'b0;
        end else begin
            y_r <= y_next_s;
            if (!A2X_) begin
                x_r <= a_r;
            end else if (any_wy_s) begin
                x_r <= {WBITS{1'b0}};
            end
            if (!CI_) begin
                ci_r <= 1'b1;
            end else if (any_wy_s) begin
                ci_r <= 1'b0;
            end
        end
    end

    // Branch bits; TOV_ decides BR2 when it coincides with TMZ_.
    always_ff @(posedge CLOCK or posedge rst) begin
        if (rst) begin
            br1_r <= 1'b0;
            br2_r <= 1'b0;
        end else if (!TOV_) begin
            br1_r <= wl_s[WBITS];
            br2_r <= wl_s[WBITS] ^ wl_s[WBITS-1];
        end else begin
            if (!TSGN_) br1_r <= wl_s[WBITS];
            if (!TMZ_)  br2_r <= minus_zero_s;
        end
    end

    assign WL   = wl_s;
    assign S    = s_r;
    assign Z15_ = ~z_r[WBITS-1];
    assign Z16_ = ~z_r[WBITS];
    assign BR1  = br1_r;
    assign BR2  = br2_r;
    assign BR1_ = ~br1_r;
    assign BR2_ = ~br2_r;

endmodule

// File: tb/tb_agc_central_regs.sv
// Randomized bench for agc_central_regs against an arithmetic model of the register set.
module tb_agc_central_regs;

    localparam int P_RA = 0,  P_RB = 1,   P_RC = 2,    P_RG = 3,   P_RL = 4,  P_RZ = 5,  P_RU = 6;
    localparam int P_WA = 7,  P_WB = 8,   P_WG = 9,    P_WL = 10,  P_WZ = 11, P_WS = 12;
    localparam int P_WY = 13, P_WYD = 14, P_WY12 = 15, P_A2X = 16, P_CI = 17;
    localparam int P_TSGN = 18, P_TOV = 19, P_TMZ = 20;

    logic        CLOCK = 1'b0;
    logic        rst;
    logic [20:0] p;
    logic [16:1] WL;
    logic [12:1] S;
    logic        Z15_, Z16_, BR1, BR2, BR1_, BR2_;

    int ma, mb, mg, ml, mz, mx, my, mci, ms, mbr1, mbr2, mwl;
    int nc = 0;
    int nf = 0;

    always #5 CLOCK = ~CLOCK;

    agc_central_regs dut (
        .CLOCK (CLOCK), .rst (rst),
        .RA_ (~p[P_RA]), .RB_ (~p[P_RB]), .RC_ (~p[P_RC]), .RG_ (~p[P_RG]),
        .RL_ (~p[P_RL]), .RZ_ (~p[P_RZ]), .RU_ (~p[P_RU]),
        .WA_ (~p[P_WA]), .WB_ (~p[P_WB]), .WG_ (~p[P_WG]), .WL_ (~p[P_WL]),
        .WZ_ (~p[P_WZ]), .WS_ (~p[P_WS]),
        .WY_ (~p[P_WY]), .WYD_ (~p[P_WYD]), .WY12_ (~p[P_WY12]),
        .A2X_ (~p[P_A2X]), .CI_ (~p[P_CI]),
        .TSGN_ (~p[P_TSGN]), .TOV_ (~p[P_TOV]), .TMZ_ (~p[P_TMZ]),
        .WL (WL), .S (S), .Z15_ (Z15_), .Z16_ (Z16_),
        .BR1 (BR1), .BR2 (BR2), .BR1_ (BR1_), .BR2_ (BR2_)
    );

    function automatic logic [20:0] pb(input int i);
        logic [20:0] one;
        one = 21'd1;
        return one << i;
    endfunction

    // Ones'-complement sum of two 16-bit words and a carry-in, folding the carry once.
    function automatic int oc(input int x, input int y, input int c);
        int s;
        s = x + y + c;
        if (s > 65535) s = s - 65535;
        return s & 65535;
    endfunction

    function automatic int bus(input logic [20:0] q);
        int w;
        w = 0;
        if (q[P_RA]) w = w | ma;
        if (q[P_RB]) w = w | mb;
        if (q[P_RC]) w = w | (mb ^ 65535);
        if (q[P_RG]) w = w | mg;
        if (q[P_RL]) w = w | ml;
        if (q[P_RZ]) w = w | mz;
        if (q[P_RU]) w = w | oc(mx, my, mci);
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input int exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        ma = 0; mb = 0; mg = 0; ml = 0; mz = 0; mx = 0; my = 0;
        mci = 0; ms = 0; mbr1 = 0; mbr2 = 0; mwl = 0;
    endtask

    // Apply this cycle's pulses and compare every output with the model.
    task automatic drive(input logic [20:0] q);
        int zexp;
        p = q;
        #3;
        mwl = bus(q);
        zexp = (~(mz >> 14)) & 3;
        check("wl", {16'd0, WL}, mwl);
        check("s", {20'd0, S}, ms);
        check("z_inv", {30'd0, Z16_, Z15_}, zexp);
        check("br", {28'd0, BR1, BR2, BR1_, BR2_},
              mbr1 * 8 + mbr2 * 4 + (1 - mbr1) * 2 + (1 - mbr2));
    endtask

    task automatic clk_edge();
        int w, sg, wy;
        int na, nb, ng, nl, nz, ns, nx, ny, nci, nb1, nb2;
        @(posedge CLOCK);
        w  = mwl;
        na = ma; nb = mb; ng = mg; nl = ml; nz = mz; ns = ms;
        nx = mx; ny = my; nci = mci; nb1 = mbr1; nb2 = mbr2;
        if (p[P_WA]) na = w;
        if (p[P_WB]) nb = w;
        if (p[P_WG]) ng = w;
        if (p[P_WL]) nl = w;
        if (p[P_WZ]) nz = w;
        if (p[P_WS]) ns = w % 4096;
        wy = (p[P_WY] || p[P_WYD] || p[P_WY12]) ? 1 : 0;
        if (p[P_WY])        ny = w;
        else if (p[P_WYD])  ny = ((w * 2) + (w / 32768)) % 65536;
        else if (p[P_WY12]) ny = w % 4096;
        if (p[P_A2X])       nx = ma;
        else if (wy == 1)   nx = 0;
        if (p[P_CI])        nci = 1;
        else if (wy == 1)   nci = 0;
        sg = w / 32768;
        if (p[P_TOV]) begin
            nb1 = sg;
            nb2 = sg ^ ((w / 16384) % 2);
        end else begin
            if (p[P_TSGN]) nb1 = sg;
            if (p[P_TMZ])  nb2 = (w == 65535) ? 1 : 0;
        end
        ma = na; mb = nb; mg = ng; ml = nl; mz = nz; ms = ns;
        mx = nx; my = ny; mci = nci; mbr1 = nb1; mbr2 = nb2;
        #1;
    endtask

    task automatic cycle(input logic [20:0] q);
        drive(q);
        clk_edge();
    endtask

    // Build A bit by bit: A = 2A + bit through the adder, then back into A.
    task automatic load_a(input int v);
        logic [20:0] q;
        cycle(pb(P_WA));
        for (int i = 15; i >= 0; i--) begin
            q = pb(P_RA) | pb(P_A2X) | pb(P_WY);
            if (((v >> i) & 1) == 1) q = q | pb(P_CI);
            cycle(q);
            cycle(pb(P_RU) | pb(P_WA));
        end
    endtask

    task automatic mid_reset(input logic [20:0] q);
        drive(q);
        #2 rst = 1'b1;
        model_reset();
        @(posedge CLOCK);
        #1 rst = 1'b0;
    endtask

    int ov_val[3] = '{32'h4000, 32'h8000, 32'hC000};
    int ov_exp[3] = '{1, 3, 2};

    initial begin
        logic [20:0] q;
        p   = 21'd0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(posedge CLOCK);
        #1 rst = 1'b0;

        drive(21'd0);
        check("rst_wl", {16'd0, WL}, 0);
        check("rst_s", {20'd0, S}, 0);
        check("rst_z_inv", {30'd0, Z16_, Z15_}, 3);
        check("rst_br", {30'd0, BR1, BR2}, 0);
        clk_edge();

        load_a(32'h1234);
        drive(pb(P_RA));
        check("ra_wl", {16'd0, WL}, 32'h1234);
        clk_edge();
        cycle(pb(P_RA) | pb(P_WB));
        drive(pb(P_RB));
        check("rb_wl", {16'd0, WL}, 32'h1234);
        clk_edge();
        drive(pb(P_RC));
        check("rc_wl", {16'd0, WL}, 32'hEDCB);
        clk_edge();

        load_a(4);
        cycle(pb(P_RA) | pb(P_WB));
        load_a(3);
        cycle(pb(P_RB) | pb(P_A2X) | pb(P_WY));
        drive(pb(P_RU));
        check("add_7", {16'd0, WL}, 7);
        clk_edge();
        cycle(pb(P_RB) | pb(P_A2X) | pb(P_WY) | pb(P_CI));
        drive(pb(P_RU));
        check("add_ci_8", {16'd0, WL}, 8);
        clk_edge();

        load_a(1);
        cycle(pb(P_RA) | pb(P_WB));
        cycle(pb(P_RC) | pb(P_WA));
        cycle(pb(P_RB) | pb(P_WYD));
        cycle(pb(P_A2X));
        drive(pb(P_RU));
        check("eac_1", {16'd0, WL}, 1);
        clk_edge();

        for (int k = 0; k < 3; k++) begin
            load_a(ov_val[k]);
            cycle(pb(P_RA) | pb(P_TOV));
            drive(21'd0);
            check("tov_br", {30'd0, BR1, BR2}, ov_exp[k]);
            clk_edge();
        end

        cycle(pb(P_WB));
        cycle(pb(P_RC) | pb(P_TMZ));
        drive(21'd0);
        check("tmz_ffff", {31'd0, BR2}, 1);
        clk_edge();
        load_a(1);
        cycle(pb(P_RA) | pb(P_WB));
        cycle(pb(P_RC) | pb(P_TMZ));
        drive(21'd0);
        check("tmz_fffe", {31'd0, BR2}, 0);
        clk_edge();
        cycle(pb(P_WB));
        cycle(pb(P_RC) | pb(P_TOV) | pb(P_TMZ));
        drive(21'd0);
        check("tov_tmz", {30'd0, BR1, BR2}, 2);
        clk_edge();

        load_a(32'hC000);
        mid_reset(pb(P_RA) | pb(P_WZ));
        drive(21'd0);
        check("mid_rst_z_inv", {30'd0, Z16_, Z15_}, 3);
        clk_edge();

        for (int n = 0; n < 600; n++) begin
            q = 21'd0;
            for (int i = 0; i < 21; i++) begin
                if ($urandom_range(0, 3) == 0) q[i] = 1'b1;
            end
            if ($urandom_range(0, 99) == 0) begin
                mid_reset(q);
            end else begin
                cycle(q);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule

// File: doc/agc_central_regs.md
# agc_central_regs

Central register and write-bus responder for the AGC control-pulse chain. Consumes the active-low read/write/test control pulses issued by the crosspoint generators each timing cycle. Drives the 16-bit write bus from the selected registers, latches registers from that bus, forms U = X + Y + CI in ones' complement, and maintains the branch bits BR1/BR2.

## Interface
Parameters:
- WBITS, 16, write-bus and register width; bit 16 is the overflow sign, bit 15 is the memory sign, bits numbered 16..1.
- SBITS, 12, S (address) register width.

Ports:
- CLOCK  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- RA_, RB_, RC_, RG_, RL_, RZ_, RU_  in  1 each  read pulses, active low. RC_ reads the complement of B.
- WA_, WB_, WG_, WL_, WZ_, WS_  in  1 each  write pulses into A, B, G, L, Z, S; active low.
- WY_, WYD_, WY12_, A2X_, CI_  in  1 each  adder-input pulses; active low.
- TSGN_, TOV_, TMZ_  in  1 each  branch test pulses; active low.
- WL  out  WBITS  write bus.
- S  out  SBITS  S register.
- Z15_, Z16_  out  1  inverted Z bits 15 and 16.
- BR1, BR2, BR1_, BR2_  out  1  branch register bits and their complements.

## Operation
- Write bus is combinational: WL = OR of every register selected by an asserted read pulse. RC_ contributes ~B. No read pulses asserted: WL = 0.
- Register writes occur on the rising CLOCK edge at the end of the cycle in which the pulse is asserted, and load that cycle's WL.
- Read and write of the same register in one cycle: WL carries the old value; the register loads WL. A reg read with a no-op write therefore keeps its value.
- Adder inputs:
  - WY_: X <= 0, Y <= WL.
  - WY12_: X <= 0, Y <= {4'b0, WL[12:1]}.
  - WYD_: X <= 0, Y <= WL rotated left one bit (bit 16 into bit 1).
  - A2X_: X <= A, overriding the clear from any WY pulse in the same cycle.
  - CI_: sets the carry-in flop CI <= 1.
  - Any WY pulse without CI_ clears CI.
  - Priority among the WY pulses: WY_ > WYD_ > WY12_.
- U = X + Y + CI, 16-bit ones' complement with end-around carry. RU_ places U on WL.
- Branch tests sample WL in the asserting cycle and update at that edge:
  - TSGN_: BR1 <= WL[16]; BR2 held.
  - TOV_: BR1 <= WL[16], BR2 <= WL[16] ^ WL[15].
  - TMZ_: BR2 <= (WL == 16'hFFFF).
  - TOV_ and TMZ_ together: TOV_ wins for BR2.
- S <= WL[12:1] on WS_.
- Reset: A, B, G, L, Z, X, Y, CI, S, BR1 and BR2 are cleared asynchronously. Outputs then read WL=0, S=0, Z15_=Z16_=1, BR1=BR2=0, BR1_=BR2_=1. Reset asserted mid-cycle discards any pending write.

## Timing
- Read-to-bus latency: zero cycles (combinational).
- Write-to-register latency: one edge.
- U is valid combinationally in the cycle after the last X/Y/CI update. So WY_ in cycle n and RU_ in cycle n+1 gives Y + carry on WL in n+1.
- Branch bits are visible the cycle after the test pulse.
- Every pulse is level-sampled each cycle. A pulse held for k cycles performs k identical transfers.

## Structure
- Package agc_creg_pkg: WBITS/SBITS constants, the minus-zero constant 16'hFFFF, and a ones'-complement add function.
- Sub-module agc_oc_adder: 16-bit end-around-carry adder with inputs X, Y, CI and output U. It is instantiated once.
- Registers, bus mux and branch logic live in the top module.

## Test plan
- Reset: pulse rst with all control pulses at 1 -> WL=0, S=0, Z15_=Z16_=1, BR1=BR2=0.
- Transfer: drive WL via WA_ while A is loaded through a preceding write-only sequence. Then RA_+WB_ with A=16'h1234 -> next cycle B=16'h1234. RC_ alone -> WL=16'hEDCB.
- Adder:
  - A=16'h0003, then A2X_+WY_ with WL=16'h0004, then RU_ -> WL=16'h0007.
  - Repeat with CI_ asserted -> WL=16'h0008.
  - X=16'hFFFE, Y=16'h0002 -> U=16'h0001 (end-around carry).
- Overflow test:
  - WL=16'h4000 with TOV_ -> BR1=0, BR2=1.
  - WL=16'h8000 -> BR1=1, BR2=1.
  - WL=16'hC000 -> BR1=1, BR2=0.
- Minus zero: WL=16'hFFFF with TMZ_ -> BR2=1. WL=16'hFFFE -> BR2=0. TOV_+TMZ_ on 16'hFFFF -> BR2=0.
- Mid-cycle reset: assert WZ_ with WL=16'hC000 and raise rst before the edge -> Z stays 0, Z15_=Z16_=1.
